// File: rtl/brick_map_ctrl_if.sv
// Command/response port between the game-logic master and the brick map.
// The master holds op/col/row stable while cmd_valid is high and waits for cmd_ready.
interface brick_map_ctrl_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_col;
  logic [4:0] cmd_row;
  logic       rsp_valid;
  logic       rsp_hit;
  logic       rsp_err;

  modport master (
    output cmd_valid, cmd_op, cmd_col, cmd_row,
    input  cmd_ready, rsp_valid, rsp_hit, rsp_err
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_col, cmd_row,
    output cmd_ready, rsp_valid, rsp_hit, rsp_err
  );
endinterface

// File: rtl/brick_map_ctrl.sv
// 32x24 brick tile map: power-on border load, per-pixel brick lookup and a
// blanking-only read-modify-write command port for game logic.
module brick_map_ctrl #(
  parameter int MAP_COLS   = 32,
  parameter int MAP_ROWS   = 24,
  parameter int TILE_SHIFT = 5
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic [11:0] pixel_column_i,
  input  logic [11:0] pixel_row_i,
  input  logic        video_on_i,
  output logic [9:0]  brick_addr_o,
  output logic        brick_en_o,
  output logic [9:0]  brick_count_o,
  output logic        init_done_o,
  brick_map_ctrl_if.slave cmd_if
);
  localparam int          ENTRIES   = MAP_COLS * MAP_ROWS;
  localparam int          TW        = 12 - TILE_SHIFT;
  localparam logic [TW-1:0] COLS_T  = TW'(MAP_COLS);
  localparam logic [TW-1:0] ROWS_T  = TW'(MAP_ROWS);
  localparam logic [4:0]  ROWS_5    = 5'(MAP_ROWS);
  localparam logic [4:0]  LAST_ROW  = 5'(MAP_ROWS - 1);
  localparam logic [4:0]  LAST_COL  = 5'(MAP_COLS - 1);
  localparam logic [9:0]  LAST_IDX  = 10'(ENTRIES - 1);
  localparam logic [9:0]  MAX_COUNT = 10'(ENTRIES);

  localparam logic [1:0] OP_SET   = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] init_ptr_q, init_ptr_d;
  logic [9:0] count_q, count_d;
  logic       init_done_q, init_done_d;
  logic       hit_q, hit_d;
  logic       err_q, err_d;
  logic [9:0] brick_addr_q, brick_addr_d;
  logic       brick_en_q, brick_en_d;

  logic       map_q [0:ENTRIES-1];
  logic       map_we;
  logic [9:0] map_wr_idx;
  logic       map_wr_bit;

  logic [TW-1:0] tile_col, tile_row;
  logic [9:0]    vid_idx;
  logic [9:0]    cmd_idx;
  logic          cmd_err;
  logic          cmd_old;
  logic          init_bit;
  logic          cmd_ready_c;

  assign tile_col = pixel_column_i[11:TILE_SHIFT];
  assign tile_row = pixel_row_i[11:TILE_SHIFT];
  assign vid_idx  = {tile_row[4:0], tile_col[4:0]};

  assign cmd_idx = {cmd_if.cmd_row, cmd_if.cmd_col};
  assign cmd_err = (cmd_if.cmd_row >= ROWS_5);
  // Rows past the map would alias beyond the array, so they read as empty.
  assign cmd_old = cmd_err ? 1'b0 : map_q[cmd_idx];

  assign init_bit = (init_ptr_q[9:5] == 5'd0) || (init_ptr_q[9:5] == LAST_ROW) ||
                    (init_ptr_q[4:0] == 5'd0) || (init_ptr_q[4:0] == LAST_COL);

  always_comb begin
    state_d     = state_q;
    init_ptr_d  = init_ptr_q;
    count_d     = count_q;
    init_done_d = init_done_q;
    hit_d       = hit_q;
    err_d       = err_q;
    map_we      = 1'b0;
    map_wr_idx  = init_ptr_q;
    map_wr_bit  = 1'b0;
    cmd_ready_c = 1'b0;

    case (state_q)
      S_INIT: begin
        map_we     = 1'b1;
        map_wr_bit = init_bit;
        if (init_bit) begin
          count_d = count_q + 10'd1;
        end
        if (init_ptr_q == LAST_IDX) begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end else begin
          init_ptr_d = init_ptr_q + 10'd1;
        end
      end

      S_IDLE: begin
        cmd_ready_c = ~video_on_i;
        if (cmd_if.cmd_valid && cmd_ready_c) begin
          hit_d      = cmd_old;
          err_d      = cmd_err;
          map_wr_idx = cmd_idx;
          state_d    = S_RESP;
          if (!cmd_err && cmd_if.cmd_op == OP_SET) begin
            map_we     = 1'b1;
            map_wr_bit = 1'b1;
            if (!cmd_old && count_q < MAX_COUNT) begin
              count_d = count_q + 10'd1;
            end
          end else if (!cmd_err && cmd_if.cmd_op == OP_CLEAR) begin
            map_we     = 1'b1;
            map_wr_bit = 1'b0;
            if (cmd_old && count_q != 10'd0) begin
              count_d = count_q - 10'd1;
            end
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_INIT;
      end
    endcase
  end

  // The video lookup is suppressed while the map is still being loaded.
  always_comb begin
    brick_addr_d = {pixel_row_i[4:0], pixel_column_i[4:0]};
    brick_en_d   = 1'b0;
    if (state_q != S_INIT && video_on_i && tile_col < COLS_T && tile_row < ROWS_T) begin
      brick_en_d = map_q[vid_idx];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= S_INIT;
      init_ptr_q   <= 10'd0;
      count_q      <= 10'd0;
      init_done_q  <= 1'b0;
      hit_q        <= 1'b0;
      err_q        <= 1'b0;
      brick_addr_q <= 10'd0;
      brick_en_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      init_ptr_q   <= init_ptr_d;
      count_q      <= count_d;
      init_done_q  <= init_done_d;
      hit_q        <= hit_d;
      err_q        <= err_d;
      brick_addr_q <= brick_addr_d;
      brick_en_q   <= brick_en_d;
    end
  end

  // Map contents need no reset: INIT rewrites every entry after each release.
  always_ff @(posedge clk_i) begin
    if (map_we) begin
      map_q[map_wr_idx] <= map_wr_bit;
    end
  end

  assign cmd_if.cmd_ready = cmd_ready_c;
  assign cmd_if.rsp_valid = (state_q == S_RESP);
  assign cmd_if.rsp_hit   = hit_q;
  assign cmd_if.rsp_err   = err_q;
  assign brick_addr_o     = brick_addr_q;
  assign brick_en_o       = brick_en_q;
  assign brick_count_o    = count_q;
  assign init_done_o      = init_done_q;
endmodule

// File: doc/brick_map_ctrl.md
Name: brick_map_ctrl

Overview:
Owns the 32x24 world tile map that records which 32x32 cells hold a brick. It also sequences the pixel-side lookup that drives the brick ROM address and enable. Game logic (bullet/tank collision, level edits) shares the map through a valid/ready command port. Commands are serviced only during blanking, so the video path never stalls. Sits between the display timing generator, the brick ROM and the game-logic master.

Parameters:
MAP_COLS, 32, tiles per row (fixed 5-bit column index)
MAP_ROWS, 24, valid tile rows (5-bit row index, rows 24..31 invalid)
TILE_SHIFT, 5, log2 of the tile size in pixels (32)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
pixel_column  in  12  current pixel x from the display timing generator
pixel_row  in  12  current pixel y from the display timing generator
video_on  in  1  1 = active display area
brick_addr  out  10  brick ROM address {pixel_row[4:0], pixel_column[4:0]}
brick_en  out  1  1 = current pixel's tile holds a brick (paint the ROM colour)
cmd_valid  in  1  command request
cmd_ready  out  1  command accepted this cycle when high together with cmd_valid
cmd_op  in  2  00 query, 01 set, 10 clear, 11 reserved (treated as query)
cmd_col  in  5  tile column 0..31
cmd_row  in  5  tile row 0..23
rsp_valid  out  1  one-cycle response strobe
rsp_hit  out  1  tile state before the command (1 = brick was present)
rsp_err  out  1  row >= 24; no map change
brick_count  out  10  number of bricks currently in the map
init_done  out  1  1 once the power-on map load has completed

Behaviour:
- Storage: 768 x 1-bit map. Index = {row[4:0], col[4:0]}. Register array, single logical access per cycle.
- Reset (reset=0, asynchronous):
  - State enters INIT with init_ptr=0.
  - brick_addr=0, brick_en=0, cmd_ready=0, rsp_valid=0, rsp_hit=0, rsp_err=0, brick_count=0, init_done=0.
- INIT state:
  - Writes one entry per cycle, in index order over the valid tiles 0..767.
  - Bit = 1 if row==0, row==23, col==0 or col==31; else 0.
  - brick_count increments on each 1 written; final value 108.
  - After the last write: state goes to IDLE and init_done=1 (registered; first high 768 cycles after reset release).
  - During INIT, cmd_ready=0 and brick_en=0.
- Reset asserted mid-INIT or mid-command aborts immediately; after release INIT restarts from index 0.
- Video path (IDLE/RESP only, 1-cycle registered latency):
  - tc = pixel_column[11:5], tr = pixel_row[11:5].
  - If video_on && tc<32 && tr<24: brick_en <= map[{tr[4:0], tc[4:0]}]; otherwise brick_en <= 0.
  - brick_addr <= {pixel_row[4:0], pixel_column[4:0]} every cycle regardless of video_on.
- Command FSM:
  - States: INIT, IDLE, RESP.
  - IDLE: cmd_ready = ~video_on (combinational).
  - Accept when cmd_valid && cmd_ready. In the same cycle: read the old bit, write the new bit (set -> 1, clear -> 0, query -> unchanged), latch rsp_hit = old bit and rsp_err = (cmd_row >= 24). Then go to RESP.
  - Out-of-range row: no write, rsp_hit=0, rsp_err=1, count unchanged.
  - RESP: rsp_valid=1 for exactly one cycle, cmd_ready=0, then return to IDLE.
  - Throughput: one command per 2 cycles. Latency: accept at cycle N, response at N+1.
  - rsp_hit and rsp_err hold their values until the next response.
- brick_count update:
  - Set on an empty tile: +1.
  - Clear on an occupied tile: -1.
  - Set on occupied, clear on empty, or query: unchanged.
  - Never wraps: maximum 768, minimum 0.
- video_on rising during RESP: the response still completes (RESP performs no map access). The map is never written while video_on=1.
- cmd_valid held high while video_on=1: the command waits with no loss. The master must hold cmd_op/cmd_col/cmd_row stable until accepted.

Test Plan:
- Reset low 3 cycles then release -> init_done rises after 768 cycles; brick_count=108; query (row 0, col 5) gives rsp_hit=1; query (row 5, col 5) gives rsp_hit=0.
- After init, video_on=0, clear (row 0, col 5) -> accepted same cycle; next cycle rsp_valid=1, rsp_hit=1; brick_count=107; a repeat clear gives rsp_hit=0 and count stays 107.
- Set (row 10, col 10) then drive pixel_column=330, pixel_row=333, video_on=1 -> next cycle brick_en=1, brick_addr={5'd13, 5'd10}=0x1AA.
- cmd_valid=1 with video_on=1 for 50 cycles -> cmd_ready=0 throughout, no rsp_valid; video_on falls -> accepted that cycle, response the next cycle.
- Set (row 24, col 3) -> rsp_err=1, rsp_hit=0, brick_count unchanged; pixel_row=800, video_on=1 -> brick_en=0.
- Assert reset during RESP and again at init_ptr=400 -> all outputs return to reset values; INIT restarts and completes 768 cycles after the final release with brick_count=108.
